// File: rtl/pi_seg_pkg.sv
// Shared types and constants for the pi seven-segment checker: FSM states,
// segment glyph codes (a..g in bits 0..6) and the reference digits of pi.
package pi_seg_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    CHECK = 2'd1,
    PASS  = 2'd2,
    FAIL  = 2'd3
  } state_t;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  // Variant glyphs some display drivers emit for 6, 7 and 9.
  localparam logic [6:0] SEG_6_ALT = 7'h7C;
  localparam logic [6:0] SEG_7_ALT = 7'h27;
  localparam logic [6:0] SEG_9_ALT = 7'h67;

  localparam int PI_MAX_LEN = 32;

  localparam logic [3:0] PI_DIGITS [PI_MAX_LEN] = '{
    4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9, 4'd2, 4'd6,
    4'd5, 4'd3, 4'd5, 4'd8, 4'd9, 4'd7, 4'd9, 4'd3,
    4'd2, 4'd3, 4'd8, 4'd4, 4'd6, 4'd2, 4'd6, 4'd4,
    4'd3, 4'd3, 4'd8, 4'd3, 4'd2, 4'd7, 4'd9, 4'd5
  };

  function automatic logic [3:0] pi_digit(input logic [4:0] idx);
    return PI_DIGITS[idx];
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational seven-segment to BCD decoder with a legality flag.
// Defining PI_SEG_ALT_GLYPH_EN additionally accepts the variant 6/7/9 glyphs.
module seg7_to_bcd
  import pi_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       legal
);

  always_comb begin
    digit = 4'd0;
    legal = 1'b1;
    case (seg)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
`ifdef PI_SEG_ALT_GLYPH_EN
      SEG_6_ALT: digit = 4'd6;
      SEG_7_ALT: digit = 4'd7;
      SEG_9_ALT: digit = 4'd9;
`endif
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/pi_seg_checker.sv
// Decodes a sampled seven-segment stream, locks on the first '3' and checks
// the following digits against pi. Glyph set is widened by PI_SEG_ALT_GLYPH_EN.
module pi_seg_checker
  import pi_seg_pkg::*;
#(
  parameter int PREFIX_LEN = 16,
  parameter int IDX_W      = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       seg_in,
  input  logic             sample_en,
  input  logic             clear,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             glyph_err,
  output logic [1:0]       state,
  output logic [IDX_W-1:0] match_count,
  output logic             pass,
  output logic             fail,
  output logic [IDX_W-1:0] err_index
);

  localparam logic [IDX_W-1:0] LAST_COUNT = IDX_W'(PREFIX_LEN);

  logic [6:0]       seg_q;
  logic             s1_valid;
  logic [3:0]       dec_digit;
  logic             dec_legal;
  logic [IDX_W-1:0] next_count;
  logic [4:0]       pi_idx;
  logic             unused_dp;
  state_t           state_q;

  assign unused_dp  = seg_in[7];
  assign next_count = match_count + IDX_W'(1);
  assign pi_idx     = 5'(match_count);
  assign state      = state_q;

  // Stage 1: capture the pattern; clear drops whatever was about to be captured.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seg_q    <= '0;
      s1_valid <= 1'b0;
    end else if (clear) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= sample_en;
      if (sample_en) begin
        seg_q <= seg_in[6:0];
      end
    end
  end

  seg7_to_bcd u_decode (
    .seg   (seg_q),
    .digit (dec_digit),
    .legal (dec_legal)
  );

  // Stage 2: decode strobes and the alignment/check FSM, all registered together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= HUNT;
      digit       <= '0;
      digit_valid <= 1'b0;
      glyph_err   <= 1'b0;
      match_count <= '0;
      err_index   <= '0;
      pass        <= 1'b0;
      fail        <= 1'b0;
    end else begin
      digit_valid <= 1'b0;
      glyph_err   <= 1'b0;
      if (clear) begin
        state_q     <= HUNT;
        digit       <= '0;
        match_count <= '0;
        err_index   <= '0;
        pass        <= 1'b0;
        fail        <= 1'b0;
      end else if (s1_valid) begin
        digit_valid <= dec_legal;
        glyph_err   <= !dec_legal;
        if (dec_legal) begin
          digit <= dec_digit;
        end
        case (state_q)
          HUNT: begin
            if (dec_legal && dec_digit == 4'd3) begin
              state_q     <= CHECK;
              match_count <= IDX_W'(1);
            end
          end
          CHECK: begin
            if (dec_legal && dec_digit == pi_digit(pi_idx)) begin
              match_count <= next_count;
              if (next_count == LAST_COUNT) begin
                state_q <= PASS;
                pass    <= 1'b1;
              end
            end else begin
              state_q   <= FAIL;
              fail      <= 1'b1;
              err_index <= match_count;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pi_seg_checker.sv
// Table-driven bench for pi_seg_checker: each row's expectations are the outputs
// seen two clock edges after that row's inputs are driven.
module tb_pi_seg_checker;

  localparam int PREFIX_LEN = 16;
  localparam int IDX_W      = 6;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [7:0]       seg_in;
  logic             sample_en;
  logic             clear;
  logic [3:0]       digit;
  logic             digit_valid;
  logic             glyph_err;
  logic [1:0]       state;
  logic [IDX_W-1:0] match_count;
  logic             pass;
  logic             fail;
  logic [IDX_W-1:0] err_index;

  typedef struct {
    logic [7:0] seg;
    logic       en;
    logic [3:0] e_digit;
    logic       e_dv;
    logic       e_ge;
    logic [1:0] e_state;
    logic [5:0] e_mc;
    logic       e_pass;
    logic       e_fail;
    logic [5:0] e_ei;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] glyph  [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                              8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
  logic [3:0] pi_ref [16] = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9, 4'd2, 4'd6,
                              4'd5, 4'd3, 4'd5, 4'd8, 4'd9, 4'd7, 4'd9, 4'd3};

  pi_seg_checker #(.PREFIX_LEN(PREFIX_LEN), .IDX_W(IDX_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .seg_in      (seg_in),
    .sample_en   (sample_en),
    .clear       (clear),
    .digit       (digit),
    .digit_valid (digit_valid),
    .glyph_err   (glyph_err),
    .state       (state),
    .match_count (match_count),
    .pass        (pass),
    .fail        (fail),
    .err_index   (err_index)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int seg, input int en, input int d, input int dv,
                              input int ge, input int st, input int mc, input int ps,
                              input int fl, input int ei);
    vec_t r;
    r.seg     = seg[7:0];
    r.en      = en[0];
    r.e_digit = d[3:0];
    r.e_dv    = dv[0];
    r.e_ge    = ge[0];
    r.e_state = st[1:0];
    r.e_mc    = mc[5:0];
    r.e_pass  = ps[0];
    r.e_fail  = fl[0];
    r.e_ei    = ei[5:0];
    return r;
  endfunction

  // Idle row: garbage on the pins, nothing sampled, outputs hold except strobes.
  task automatic push_idle();
    vec_t r;
    r        = (vecs.size() > 0) ? vecs[$] : mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    r.seg    = 8'hFF;
    r.en     = 1'b0;
    r.e_dv   = 1'b0;
    r.e_ge   = 1'b0;
    vecs.push_back(r);
  endtask

  task automatic push_prefix(input int n, input int dp, input int gap_max);
    for (int j = 0; j < n; j++) begin
      if (gap_max > 0 && j > 0) begin
        int gaps = int'($urandom_range(gap_max, 1));
        for (int g = 0; g < gaps; g++) push_idle();
      end
      vecs.push_back(mk(int'(glyph[pi_ref[j]]) | (dp != 0 ? 'h80 : 0), 1, int'(pi_ref[j]),
                        1, 0, (j + 1 == PREFIX_LEN) ? 2 : 1, j + 1,
                        (j + 1 == PREFIX_LEN) ? 1 : 0, 0, 0));
    end
  endtask

  task automatic check_field(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_output(input string tag, input int idx, input vec_t v);
    string n;
    n = $sformatf("%s[%0d]", tag, idx);
    check_field({n, ".digit"},       32'(digit),       32'(v.e_digit));
    check_field({n, ".digit_valid"}, 32'(digit_valid), 32'(v.e_dv));
    check_field({n, ".glyph_err"},   32'(glyph_err),   32'(v.e_ge));
    check_field({n, ".state"},       32'(state),       32'(v.e_state));
    check_field({n, ".match_count"}, 32'(match_count), 32'(v.e_mc));
    check_field({n, ".pass"},        32'(pass),        32'(v.e_pass));
    check_field({n, ".fail"},        32'(fail),        32'(v.e_fail));
    check_field({n, ".err_index"},   32'(err_index),   32'(v.e_ei));
  endtask

  task automatic apply_stimulus(input string tag);
    int n;
    n = vecs.size();
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      if (k >= 2) check_output(tag, k - 2, vecs[k - 2]);
      if (k < n) begin
        seg_in    = vecs[k].seg;
        sample_en = vecs[k].en;
      end else begin
        sample_en = 1'b0;
      end
    end
    vecs.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    sample_en = 1'b0;
    clear     = 1'b0;
    @(negedge clk);
    reset_n   = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t zero;
    zero      = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset_n   = 1'b0;
    clear     = 1'b0;
    sample_en = 1'b1;
    seg_in    = 8'h4F;
    repeat (3) @(negedge clk);
    check_output("reset", 0, zero);
    reset_n   = 1'b1;
    sample_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output("reset_hold", 0, zero);

    // Full prefix back-to-back, then sticky PASS with a legal and an illegal glyph.
    push_prefix(16, 0, 0);
    vecs.push_back(mk('h4F, 1, 3, 1, 0, 2, 16, 1, 0, 0));
    vecs.push_back(mk('h00, 1, 3, 0, 1, 2, 16, 1, 0, 0));
    apply_stimulus("prefix");

    do_reset();
    vecs.push_back(mk('h06, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk('h5B, 1, 2, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk('h00, 1, 2, 0, 1, 0, 0, 0, 0, 0));
    push_prefix(16, 1, 0);
    apply_stimulus("hunt");

    do_reset();
    push_prefix(4, 0, 0);
    vecs.push_back(mk('h7D, 1, 6, 1, 0, 3, 4, 0, 1, 4));
    vecs.push_back(mk('h6D, 1, 5, 1, 0, 3, 4, 0, 1, 4));
    vecs.push_back(mk('h4F, 1, 3, 1, 0, 3, 4, 0, 1, 4));
    apply_stimulus("mismatch");

    do_reset();
    push_prefix(2, 0, 0);
    vecs.push_back(mk('h00, 1, 1, 0, 1, 3, 2, 0, 1, 2));
    apply_stimulus("illegal");

    do_reset();
    push_prefix(7, 0, 0);
`ifdef PI_SEG_ALT_GLYPH_EN
    vecs.push_back(mk('h7C, 1, 6, 1, 0, 1, 8, 0, 0, 0));
    vecs.push_back(mk('h6D, 1, 5, 1, 0, 1, 9, 0, 0, 0));
`else
    vecs.push_back(mk('h7C, 1, 2, 0, 1, 3, 7, 0, 1, 7));
    vecs.push_back(mk('h6D, 1, 5, 1, 0, 3, 7, 0, 1, 7));
`endif
    apply_stimulus("alt6");

    do_reset();
    push_prefix(16, 0, 5);
    apply_stimulus("gaps");

    // Reset while a sample sits in stage 1 at match_count 9.
    do_reset();
    push_prefix(9, 0, 0);
    apply_stimulus("pre_rst");
    @(negedge clk);
    seg_in    = glyph[pi_ref[9]];
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    reset_n   = 1'b0;
    @(negedge clk);
    check_output("rst_mid", 0, zero);
    reset_n = 1'b1;
    @(negedge clk);
    check_output("rst_mid_after", 0, zero);
    push_prefix(16, 0, 0);
    apply_stimulus("post_rst");

    // Clear colliding with a '3' sample while digit 8 is still in flight.
    do_reset();
    push_prefix(8, 0, 0);
    apply_stimulus("pre_clr");
    @(negedge clk);
    seg_in    = glyph[pi_ref[8]];
    sample_en = 1'b1;
    @(negedge clk);
    seg_in    = glyph[3];
    sample_en = 1'b1;
    clear     = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    clear     = 1'b0;
    check_output("clr", 0, zero);
    @(negedge clk);
    check_output("clr_after", 0, zero);
    push_prefix(16, 0, 0);
    apply_stimulus("post_clr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
